// File: rtl/adat_pkg.sv
// -----------------------------------------------------------------------------
// adat_pkg
// Shared constants, state type and a small helper for the ADAT frame
// transmitter.
//   ADAT_FRAME_BITS        bits per ADAT frame on the line
//   ADAT_SYNC_ZEROS        leading zeros of the sync pattern
//   ADAT_CHANNELS          audio channels per frame
//   ADAT_SAMPLE_BITS       transmitted bits per channel sample
//   ADAT_SLOT_BITS         bits per channel slot in the channel buffer
//   ADAT_NIBBLES           nibbles per sample on the line
//   ADAT_NIBBLE_DATA_BITS  data bits per nibble (a separator 1 follows each)
// -----------------------------------------------------------------------------
package adat_pkg;

   localparam int ADAT_FRAME_BITS       = 256;
   localparam int ADAT_SYNC_ZEROS       = 10;
   localparam int ADAT_CHANNELS         = 8;
   localparam int ADAT_SAMPLE_BITS      = 24;
   localparam int ADAT_SLOT_BITS        = 32;
   localparam int ADAT_NIBBLES          = 6;
   localparam int ADAT_NIBBLE_DATA_BITS = ADAT_SAMPLE_BITS / ADAT_NIBBLES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      USER = 2'd2,
      DATA = 2'd3
   } adat_tx_state_t;

   // Sample bit index (MSB first) inside a channel slot from nibble/bit counters.
   function automatic logic [$clog2(ADAT_SLOT_BITS)-1:0] adat_sample_bit(
      input logic [2:0] nib,
      input logic [2:0] nbit
   );
      return {nib, 2'b00} + {2'b00, nbit};
   endfunction

endpackage

// File: rtl/adat_nrzi_encoder.sv
// -----------------------------------------------------------------------------
// adat_nrzi_encoder
// NRZI line coder: a logical 1 toggles the line on a bit tick, a 0 keeps it.
//   clk       system clock
//   rst       asynchronous active-high reset, line forced to 0
//   tick      one-cycle bit strobe
//   data_bit  logical bit to emit on this tick
//   line      NRZI-coded output
// -----------------------------------------------------------------------------
module adat_nrzi_encoder (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic data_bit,
   output logic line
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line <= 1'b0;
      end else if (tick && data_bit) begin
         line <= ~line;
      end
   end

endmodule

// File: rtl/adat_frame_transmitter.sv
// -----------------------------------------------------------------------------
// adat_frame_transmitter
// Reads 256-bit frames from the receiver's circular channel_buffer and sends
// them as an NRZI ADAT stream, staying one frame behind the writer and
// flagging underrun when the writer has not finished the next frame.
//   clk_i                  system clock
//   rst_i                  asynchronous active-high reset
//   enable_i               start / continue transmission
//   ram_data_i             channel_buffer read data, valid the cycle after the address
//   last_good_frame_idx_i  newest fully written frame slot
//   ram_read_addr_o        channel_buffer read address {frame, channel, bit}
//   adat_running_o         high while frames are being sent
//   underrun_o             one-cycle pulse at an underrun frame boundary
//   adat_o                 NRZI ADAT line
//   state_o                current transmitter state (debug observation)
// Build option: ADAT_MUTE_ON_UNDERRUN_EN -- an underrun frame carries all-zero
// sample data instead of repeating the previous frame's buffer contents.
// -----------------------------------------------------------------------------
module adat_frame_transmitter
   import adat_pkg::*;
#(
   parameter int CIRC_BUF_BITS = 3,
   parameter int BIT_CLK_DIV   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     ram_data_i,
   input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
   output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
   output logic                     adat_running_o,
   output logic                     underrun_o,
   output logic                     adat_o,
   output adat_tx_state_t           state_o
);

   localparam int DIV_W = $clog2(BIT_CLK_DIV);
`ifdef ADAT_MUTE_ON_UNDERRUN_EN
   localparam logic MUTE_EN = 1'b1;
`else
   localparam logic MUTE_EN = 1'b0;
`endif
   localparam logic [7:0] LAST_POS      = 8'(ADAT_FRAME_BITS - 1);
   localparam logic [7:0] SYNC_ONE_POS  = 8'(ADAT_SYNC_ZEROS);
   localparam logic [7:0] USER_LAST_POS = 8'(ADAT_SYNC_ZEROS + 5);
   localparam logic [2:0] SEP_NBIT      = 3'(ADAT_NIBBLE_DATA_BITS);
   localparam logic [2:0] LAST_NIB      = 3'(ADAT_NIBBLES - 1);
   localparam logic [2:0] LAST_CH       = 3'(ADAT_CHANNELS - 1);

   adat_tx_state_t           state, state_n;
   logic [DIV_W-1:0]         div_cnt;
   logic                     tick;
   logic [7:0]               pos;
   logic [2:0]               ch, nib, nbit;
   logic [2:0]               ch_n, nib_n, nbit_n;
   logic [CIRC_BUF_BITS-1:0] rd_frame, lg_q;
   logic                     lg_valid, lg_changed, start_pend;
   logic                     next_bit_r, fetch, fetch_q, mute_r, cur_bit;
   logic [CIRC_BUF_BITS+7:0] fetch_addr;

   assign tick           = (div_cnt == DIV_W'(BIT_CLK_DIV - 1));
   // lg_valid keeps the first sample after reset from looking like a change.
   assign lg_changed     = lg_valid && (last_good_frame_idx_i != lg_q);
   assign adat_running_o = (state != IDLE);
   assign state_o        = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (tick && start_pend)       state_n = SYNC;
         SYNC:    if (tick && pos == SYNC_ONE_POS)  state_n = USER;
         USER:    if (tick && pos == USER_LAST_POS) state_n = DATA;
         DATA:    if (tick && pos == LAST_POS)  state_n = enable_i ? SYNC : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Counters for the bit after the current one; they wrap to channel 0 at
   // the end of the frame, ready for the next frame's first sample bit.
   always_comb begin
      nbit_n = nbit + 3'd1;
      nib_n  = nib;
      ch_n   = ch;
      if (nbit == SEP_NBIT) begin
         nbit_n = '0;
         if (nib == LAST_NIB) begin
            nib_n = '0;
            ch_n  = (ch == LAST_CH) ? '0 : ch + 3'd1;
         end else begin
            nib_n = nib + 3'd1;
         end
      end
   end

   always_comb begin
      cur_bit = 1'b0;
      case (state)
         SYNC:    cur_bit = (pos == SYNC_ONE_POS);
         USER:    cur_bit = (pos == USER_LAST_POS);
         DATA:    cur_bit = (nbit == SEP_NBIT) | (next_bit_r & ~mute_r);
         default: cur_bit = 1'b0;
      endcase
   end

   // Address of the next bit, issued one bit period ahead so the registered
   // read data is in next_bit_r by the following tick.
   always_comb begin
      fetch      = 1'b0;
      fetch_addr = {rd_frame, 8'd0};
      if (!mute_r) begin
         if (state == USER && pos == USER_LAST_POS) begin
            fetch = 1'b1;
         end else if (state == DATA && pos != LAST_POS && nbit_n != SEP_NBIT) begin
            fetch      = 1'b1;
            fetch_addr = {rd_frame, ch_n, adat_sample_bit(nib_n, nbit_n)};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_cnt         <= '0;
         pos             <= '0;
         ch              <= '0;
         nib             <= '0;
         nbit            <= '0;
         rd_frame        <= '0;
         lg_q            <= '0;
         lg_valid        <= 1'b0;
         start_pend      <= 1'b0;
         next_bit_r      <= 1'b0;
         fetch_q         <= 1'b0;
         mute_r          <= 1'b0;
         underrun_o      <= 1'b0;
         ram_read_addr_o <= '0;
      end else begin
         div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
         lg_q       <= last_good_frame_idx_i;
         lg_valid   <= 1'b1;
         fetch_q    <= tick & fetch;
         underrun_o <= 1'b0;
         if (fetch_q) next_bit_r <= ram_data_i;

         if (state == IDLE) begin
            pos    <= '0;
            ch     <= '0;
            nib    <= '0;
            nbit   <= '0;
            mute_r <= 1'b0;
            if (enable_i && lg_changed) rd_frame <= last_good_frame_idx_i;
            if (tick && start_pend)          start_pend <= 1'b0;
            else if (enable_i && lg_changed) start_pend <= 1'b1;
         end else if (tick) begin
            pos <= pos + 8'd1;
            if (state == DATA) begin
               ch   <= ch_n;
               nib  <= nib_n;
               nbit <= nbit_n;
            end
            if (fetch) ram_read_addr_o <= fetch_addr;
            // Live last_good is compared so a same-cycle update counts.
            if (pos == LAST_POS && enable_i) begin
               if (rd_frame == last_good_frame_idx_i) begin
                  underrun_o <= 1'b1;
                  mute_r     <= MUTE_EN;
               end else begin
                  rd_frame   <= rd_frame + CIRC_BUF_BITS'(1);
                  mute_r     <= 1'b0;
               end
            end
         end
      end
   end

   adat_nrzi_encoder u_nrzi (
      .clk      (clk_i),
      .rst      (rst_i),
      .tick     (tick && (state != IDLE)),
      .data_bit (cur_bit),
      .line     (adat_o)
   );

endmodule

// File: tb/tb_adat_frame_transmitter.sv
// -----------------------------------------------------------------------------
// tb_adat_frame_transmitter
// Bench for adat_frame_transmitter with BIT_CLK_DIV=2. A line monitor decodes
// NRZI bits on the bit ticks and pops the expected bit stream that the test
// sequence pushes for every frame it arranges to be sent.
// -----------------------------------------------------------------------------
module tb_adat_frame_transmitter;
   import adat_pkg::*;

   localparam int CB  = 3;
   localparam int DIV = 2;

   logic          clk      = 1'b0;
   logic          rst_i    = 1'b1;
   logic          enable_i = 1'b0;
   logic [CB-1:0] lg       = '0;
   logic          ram_data;
   logic [CB+7:0] addr;
   logic          running, underrun, adat;
   adat_tx_state_t state;
   logic [2047:0] mem = '0;

   assign ram_data = mem[addr];

   adat_frame_transmitter #(.CIRC_BUF_BITS(CB), .BIT_CLK_DIV(DIV)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst_i),
      .enable_i              (enable_i),
      .ram_data_i            (ram_data),
      .last_good_frame_idx_i (lg),
      .ram_read_addr_o       (addr),
      .adat_running_o        (running),
      .underrun_o            (underrun),
      .adat_o                (adat),
      .state_o               (state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Logical bit p of frame f straight from the frame layout.
   function automatic logic fbit(input int f, input int p, input logic mute);
      int q, c, r, n, b;
      if (p < 10)  return 1'b0;
      if (p == 10) return 1'b1;
      if (p < 15)  return 1'b0;
      if (p == 15) return 1'b1;
      q = p - 16;
      c = q / 30;
      r = q % 30;
      n = r / 5;
      b = r % 5;
      if (b == 4) return 1'b1;
      if (mute)   return 1'b0;
      return mem[f * 256 + c * 32 + n * 4 + b];
   endfunction

   task automatic push_frame(input int f, input logic mute);
      for (int p = 0; p < 256; p++) exp_q.push_back(fbit(f, p, mute));
   endtask

   // ---------------- line monitor ----------------
   int   bdiv = 0;
   int   mon_p = 0;
   int   tog_cnt = 0;
   int   ur_pulses = 0;
   int   ur_cycles = 0;
   logic pre_line, pre_run, pre_tick, pre_rst, ur_prev;

   initial begin
      ur_prev = 1'b0;
      forever begin
         logic got;
         @(negedge clk);
         pre_line = adat;
         pre_run  = running;
         pre_tick = (bdiv == DIV - 1);
         pre_rst  = rst_i;
         @(posedge clk);
         if (rst_i) bdiv = 0;
         else       bdiv = pre_tick ? 0 : bdiv + 1;
         #1;
         if (rst_i) begin
            mon_p   = 0;
            ur_prev = 1'b0;
         end else if (!pre_rst) begin
            if (pre_run && pre_tick) begin
               got = adat ^ pre_line;
               if (got) tog_cnt++;
               check("bit_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) check($sformatf("line_bit_p%0d", mon_p), 32'(got), 32'(exp_q.pop_front()));
               mon_p = (mon_p + 1) % 256;
            end else begin
               check("line_hold", 32'(adat), 32'(pre_line));
            end
            if (underrun) begin
               ur_cycles++;
               if (!ur_prev) ur_pulses++;
            end
            ur_prev = underrun;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_p(input int target, input string name);
      int k = 0;
      while (mon_p != target && k < 1200) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(mon_p), 32'(target));
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (running && k < 1200) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(running), 32'd0);
   endtask

   // ---------------- idle vector table ----------------
   typedef struct {
      logic          en;
      logic [CB-1:0] lgv;
      int            cyc;
      logic          exp_run;
      logic          exp_line;
      logic [CB+7:0] exp_addr;
   } idle_vec_t;

   idle_vec_t tbl[4];

   initial begin
      logic held;
      int   k;

      tbl[0] = '{1'b1, 3'd0, 60, 1'b0, 1'b0, 11'd0};  // enabled, last_good steady
      tbl[1] = '{1'b0, 3'd5, 20, 1'b0, 1'b0, 11'd0};  // change while disabled
      tbl[2] = '{1'b1, 3'd5, 60, 1'b0, 1'b0, 11'd0};  // enable without a change
      tbl[3] = '{1'b0, 3'd2, 20, 1'b0, 1'b0, 11'd0};  // another disabled change

      // reset state
      cycles(3);
      check("rst_line", 32'(adat), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      rst_i = 1'b0;

      // test 1: no start without enable plus a last_good change
      for (int i = 0; i < 4; i++) begin
         enable_i = tbl[i].en;
         lg       = tbl[i].lgv;
         cycles(tbl[i].cyc);
         check($sformatf("idle%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
         check($sformatf("idle%0d_line", i), 32'(adat), 32'(tbl[i].exp_line));
         check($sformatf("idle%0d_addr", i), 32'(addr), 32'(tbl[i].exp_addr));
         check($sformatf("idle%0d_state", i), 32'(state), 32'(IDLE));
      end

      // test 2: all-zero buffer, one frame, toggle count
      enable_i = 1'b0;
      lg = 3'd0;
      cycles(3);
      push_frame(1, 1'b0);
      tog_cnt = 0;
      ur_pulses = 0;
      enable_i = 1'b1;
      lg = 3'd1;
      k = 0;
      while (!running && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("t2_running_rise", 32'(running), 32'd1);
      wait_p(128, "t2_mid_frame");
      enable_i = 1'b0;
      cycles(4);
      wait_idle("t2_idle");
      check("t2_toggles", 32'(tog_cnt), 32'd50);
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t2_no_underrun", 32'(ur_pulses), 32'd0);

      // test 3: random buffer, writer advancing 1..7,0
      for (int i = 0; i < 64; i++) mem[i * 32 +: 32] = $urandom();
      enable_i = 1'b0;
      lg = 3'd0;
      cycles(3);
      ur_pulses = 0;
      for (int f = 1; f <= 8; f++) push_frame(f % 8, 1'b0);
      enable_i = 1'b1;
      lg = 3'd1;
      for (int f = 0; f < 8; f++) begin
         wait_p(128, $sformatf("t3_frame%0d_mid", f));
         if (f < 7) lg = 3'((f + 2) % 8);
         else       enable_i = 1'b0;
         cycles(4);
      end
      wait_idle("t3_idle");
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t3_no_underrun", 32'(ur_pulses), 32'd0);

      // test 4: writer frozen at 3 -> underrun at each enabled frame end
      enable_i = 1'b0;
      lg = 3'd2;
      cycles(3);
      ur_pulses = 0;
      ur_cycles = 0;
      push_frame(3, 1'b0);
`ifdef ADAT_MUTE_ON_UNDERRUN_EN
      push_frame(3, 1'b1);
      push_frame(3, 1'b1);
`else
      push_frame(3, 1'b0);
      push_frame(3, 1'b0);
`endif
      enable_i = 1'b1;
      lg = 3'd3;
      for (int f = 0; f < 3; f++) begin
         wait_p(128, $sformatf("t4_frame%0d_mid", f));
         if (f == 2) enable_i = 1'b0;
         cycles(4);
      end
      wait_idle("t4_idle");
      check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t4_underrun_pulses", 32'(ur_pulses), 32'd2);
      check("t4_underrun_cycles", 32'(ur_cycles), 32'd2);

      // test 5a: enable dropped at p=100, frame still completes
      push_frame(4, 1'b0);
      enable_i = 1'b1;
      lg = 3'd4;
      wait_p(100, "t5_p100");
      enable_i = 1'b0;
      cycles(4);
      wait_idle("t5_idle");
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      held = adat;
      cycles(40);
      check("t5_line_held", 32'(adat), 32'(held));
      check("t5_state_idle", 32'(state), 32'(IDLE));

      // test 5b: reset mid-frame drops the line at once
      push_frame(5, 1'b0);
      enable_i = 1'b1;
      lg = 3'd5;
      wait_p(50, "t5_p50");
      k = 0;
      while (adat !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("t5_line_high_before_rst", 32'(adat), 32'd1);
      rst_i = 1'b1;
      #1;
      check("t5_rst_line", 32'(adat), 32'd0);
      check("t5_rst_running", 32'(running), 32'd0);
      check("t5_rst_addr", 32'(addr), 32'd0);
      check("t5_rst_underrun", 32'(underrun), 32'd0);
      exp_q.delete();
      cycles(3);
      rst_i = 1'b0;
      cycles(600);
      check("t5_post_rst_running", 32'(running), 32'd0);
      check("t5_post_rst_line", 32'(adat), 32'd0);
      check("t5_post_rst_state", 32'(state), 32'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
